pe_line_buffer: RTL
===================

Name: pe_line_buffer

Overview:
- Sits directly downstream of the priority-evaluation stage.
- Captures one resolved BGR555 pixel per column strobe into a ping-pong pair of 240-entry scanline banks.
- The display/scan-out logic reads the completed line from the front bank while the next line fills the back bank.
- Bank swap is handshaked with the consumer, and a line counter tracks position within the 228-line frame.

Parameters:
VISIBLE_COLS, 240, columns stored per line; cols >= this are accepted for timing but not written
TOTAL_COLS, 308, dots per line; col TOTAL_COLS-1 marks end of line
TOTAL_LINES, 228, lines per frame; line_count wraps at this
PIX_W, 15, pixel width (BGR555)

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-low; reset==0 at posedge clock resets all state
pix_valid  in  1  one-cycle strobe: pix_col/pix_data valid (at most 1 per 4 cycles upstream, but block accepts every cycle)
pix_col  in  10  column of pixel, 0..TOTAL_COLS-1
pix_data  in  PIX_W  resolved pixel colour
rd_en  in  1  consumer read request
rd_addr  in  8  column to read from front bank
rd_data  out  PIX_W  front-bank pixel, valid 1 cycle after rd_en
rd_line_done  in  1  one-cycle pulse: consumer finished with current front bank
front_bank  out  1  index of bank currently readable
line_ready  out  1  one-cycle pulse: new line swapped to front
overrun  out  1  sticky: a line was dropped because consumer did not release in time
line_count  out  8  index of line most recently completed by writer, 0..TOTAL_LINES-1

Behaviour:
- Reset values: front_bank=0, line_ready=0, overrun=0, line_count=TOTAL_LINES-1, rd_data=0, state=FILL, rel_pending=1 (front empty, treated as released). Bank contents are not cleared.
- Write path: on pix_valid with pix_col < VISIBLE_COLS, write pix_data into back bank (~front_bank) at address pix_col.
  - Duplicate columns overwrite.
  - pix_col in VISIBLE_COLS..TOTAL_COLS-1 causes no write.
  - pix_col >= TOTAL_COLS is ignored entirely (no write, no end-of-line).
- rel_pending: set by rd_line_done; cleared on swap. rd_line_done while already set has no effect.
- End of line (EOL) is pix_valid with pix_col==TOTAL_COLS-1. On EOL, line_count increments, wrapping TOTAL_LINES-1 -> 0.
- State FILL:
  - On EOL with rel_pending=1 (or rd_line_done the same cycle): swap; stay FILL.
  - On EOL with rel_pending=0: go HOLD.
- State HOLD (back bank full, waiting for consumer):
  - rd_line_done: swap, go FILL.
  - pix_valid with pix_col==0 and no rd_line_done the same cycle: set overrun, go FILL without swap; the back bank is overwritten (line dropped). This pixel is written.
  - rd_line_done and pix_col==0 in the same cycle: swap wins, no overrun; the pixel is written into the post-swap back bank (the old front).
  - Other pix_valid in HOLD: ignored (no write).
- Swap: front_bank toggles at the clock edge. line_ready is 1 for exactly the cycle after that edge (the cycle in which front_bank shows the new value).
- Read path:
  - rd_addr and the bank index are registered on rd_en. rd_data updates the next cycle and holds when rd_en=0.
  - A read issued in the swap cycle returns old-front data.
  - rd_addr >= VISIBLE_COLS returns 0.
- Reset asserted mid-line: next line restarts in FILL into bank 1; partially written data is left stale. Consumer must wait for line_ready.
- overrun clears only on reset.

Decomposition:
- Shared package pe_pkg holds: pixel_t (logic [14:0]), col_t (logic [9:0]), the constants VISIBLE_COLS/TOTAL_COLS/TOTAL_LINES, and enum lb_state_t {FILL, HOLD}.
- One sub-module, pe_line_bank: simple dual-port RAM, VISIBLE_COLS x PIX_W, one write port, synchronous read port, 1-cycle latency. Instantiated twice.
- Top-level owns the FSM, rel_pending, counters and output muxing.

Test Plan:
- Reset, then write cols 0..239 with data=col, cols 240..307 with data=0x7FFF, then read 0..239 -> one line_ready pulse 1 cycle after the col-307 edge, front_bank=1, rd_data==addr, line_count==0.
- Second line without rd_line_done, then pix_col=0 strobe -> state HOLD after col 307, overrun=1 on col 0, no line_ready, front_bank stays 1.
- In HOLD, pulse rd_line_done alone -> swap, front_bank=0, line_ready once, overrun stays 0 (fresh reset).
- In HOLD, rd_line_done coincident with col-0 pixel 0x1234 -> swap, no overrun; after the next swap, reading addr 0 returns 0x1234.
- Run 228 lines with prompt rd_line_done -> line_count goes 227->0 at wrap; 228 line_ready pulses; rd_addr=250 returns 0.
- Assert reset (low) mid-line at col 100 -> all outputs return to reset values the next cycle; the following complete line produces line_ready with front_bank=1.

Source files
------------

// File: rtl/pe_line_buffer_pkg.sv
// Shared types and frame geometry for the priority-evaluation line buffer.
package pe_pkg;

    localparam int PIX_W        = 15;
    localparam int VISIBLE_COLS = 240;
    localparam int TOTAL_COLS   = 308;
    localparam int TOTAL_LINES  = 228;
    localparam int ADDR_W       = $clog2(VISIBLE_COLS);

    typedef logic [PIX_W-1:0]  pixel_t;
    typedef logic [9:0]        col_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } lb_state_t;

    // Read request captured on rd_en; hit=0 forces rd_data to zero.
    typedef struct packed {
        logic hit;
        logic bank;
    } rd_req_t;

    function automatic logic [7:0] next_line(input logic [7:0] cur);
        return (cur == 8'(TOTAL_LINES - 1)) ? 8'd0 : cur + 8'd1;
    endfunction

endpackage

// File: rtl/pe_line_bank.sv
// One scanline bank: simple dual-port RAM, one write port, registered read.
module pe_line_bank
    import pe_pkg::*;
#(
    parameter int DEPTH = VISIBLE_COLS,
    parameter int W     = PIX_W,
    parameter int AW    = ADDR_W
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Output register only moves on a read, so rd_data holds between reads.
    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pe_line_buffer.sv
// Ping-pong scanline buffer between priority evaluation and scan-out.
// Writer fills the back bank; consumer reads the front and releases it.
module pe_line_buffer
    import pe_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic [9:0]       pix_col,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             rd_en,
    input  logic [7:0]       rd_addr,
    output logic [PIX_W-1:0] rd_data,
    input  logic             rd_line_done,
    output logic             front_bank,
    output logic             line_ready,
    output logic             overrun,
    output logic [7:0]       line_count
);

    lb_state_t state, state_nxt;
    logic      rel_pending;
    logic      swap, ovr_set, wr_en, wr_bank, cnt_inc;
    logic      eol, col0, in_vis, rd_hit;
    rd_req_t   rd_req;
    logic [1:0][PIX_W-1:0] bank_q;

    assign eol    = pix_valid && (pix_col == col_t'(TOTAL_COLS - 1));
    assign col0   = pix_valid && (pix_col == '0);
    assign in_vis = pix_valid && (pix_col < col_t'(VISIBLE_COLS));
    assign rd_hit = rd_addr < 8'(VISIBLE_COLS);

    always_ff @(posedge clock) begin
        if (!reset)
            state <= FILL;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (eol && !(rel_pending || rd_line_done)) state_nxt = HOLD;
            HOLD: if (rd_line_done || col0)                  state_nxt = FILL;
            default:                                         state_nxt = FILL;
        endcase
    end

    // In HOLD a col-0 pixel with a same-cycle release lands in the old front,
    // which becomes the back bank at this edge.
    always_comb begin
        swap    = 1'b0;
        ovr_set = 1'b0;
        wr_en   = 1'b0;
        wr_bank = ~front_bank;
        cnt_inc = 1'b0;
        case (state)
            FILL: begin
                wr_en = in_vis;
                if (eol) begin
                    cnt_inc = 1'b1;
                    swap    = rel_pending || rd_line_done;
                end
            end
            HOLD: begin
                if (rd_line_done) begin
                    swap = 1'b1;
                    if (col0) begin
                        wr_en   = 1'b1;
                        wr_bank = front_bank;
                    end
                end else if (col0) begin
                    ovr_set = 1'b1;
                    wr_en   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            front_bank  <= 1'b0;
            line_ready  <= 1'b0;
            overrun     <= 1'b0;
            line_count  <= 8'(TOTAL_LINES - 1);
            rel_pending <= 1'b1;
            rd_req      <= '0;
        end else begin
            line_ready <= swap;
            if (swap)
                front_bank <= ~front_bank;
            if (ovr_set)
                overrun <= 1'b1;
            if (cnt_inc)
                line_count <= next_line(line_count);
            if (swap)
                rel_pending <= 1'b0;
            else if (rd_line_done)
                rel_pending <= 1'b1;
            if (rd_en) begin
                rd_req.hit  <= rd_hit;
                rd_req.bank <= front_bank;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        pe_line_bank u_bank (
            .clock   (clock),
            .wr_en   (wr_en && (wr_bank == 1'(b))),
            .wr_addr (pix_col[ADDR_W-1:0]),
            .wr_data (pix_data),
            .rd_en   (rd_en && rd_hit),
            .rd_addr (rd_addr[ADDR_W-1:0]),
            .rd_data (bank_q[b])
        );
    end

    assign rd_data = rd_req.hit ? bank_q[rd_req.bank] : '0;

endmodule
